// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared constants for the data-bus responder.
//   - MMIO register offsets within the MMIO page (word aligned)
//   - STATUS register bit positions
//   - default MMIO page selector (cpu_addr[15:12])
//   - read-mux source select encoding
//   - count display saturation helper
// -----------------------------------------------------------------------------
package dbus_pkg;

    // Register offsets within the MMIO page, cpu_addr[11:0] with [1:0] forced 0
    localparam logic [11:0] OFF_TIME    = 12'h000;
    localparam logic [11:0] OFF_TIMECMP = 12'h004;
    localparam logic [11:0] OFF_STATUS  = 12'h008;
    localparam logic [11:0] OFF_TXDATA  = 12'h00C;

    // STATUS bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_MATCH  = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_HI = 6;

    // Page value of cpu_addr[15:12] that selects the MMIO block
    localparam logic [3:0] MMIO_PAGE_DEFAULT = 4'hF;

    // Source of cpu_out in the cycle after the request
    typedef enum logic {
        SEL_RAM  = 1'b0,
        SEL_MMIO = 1'b1
    } sel_e;

    // The STATUS count field is 3 bits wide; deeper FIFOs show 7 when fuller.
    function automatic logic [2:0] sat_count3(input logic [31:0] cnt);
        return (cnt > 32'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// -----------------------------------------------------------------------------
// dbus_responder_if
// Bundle of every bus signal of the responder except clk/rst.
//   CPU port : cpu_addr, cpu_in, cpu_wen (to responder), cpu_out (to CPU)
//   RAM port : ram_addr, ram_in, ram_wen (to RAM), ram_out (from RAM)
//   TX drain : tx_data, tx_valid (to consumer), tx_ready (from consumer)
//   IRQ      : timer_irq (to CPU)
// Handshake (TX drain): a byte transfers on a rising clk edge where
// tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data
// holds its value; tx_valid never drops without a transfer except on reset.
// modport slave  : the responder's view
// modport master : the view of the surrounding system (CPU, RAM, consumer)
// -----------------------------------------------------------------------------
interface dbus_responder_if;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_in;
    logic        cpu_wen;
    logic [31:0] cpu_out;
    logic [15:0] ram_addr;
    logic [31:0] ram_in;
    logic        ram_wen;
    logic [31:0] ram_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    modport slave (
        input  cpu_addr, cpu_in, cpu_wen, ram_out, tx_ready,
        output cpu_out, ram_addr, ram_in, ram_wen, tx_data, tx_valid, timer_irq
    );

    modport master (
        output cpu_addr, cpu_in, cpu_wen, ram_out, tx_ready,
        input  cpu_out, ram_addr, ram_in, ram_wen, tx_data, tx_valid, timer_irq
    );
endinterface

// File: rtl/dbus_responder_tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_fifo
// Synchronous FIFO with show-ahead head output.
//   clk, rst  : clock, synchronous active-high reset (flushes contents)
//   i_push    : write i_data; accepted when not full or when popping too
//   i_data    : byte to write
//   i_pop     : remove head; ignored when empty
//   o_data    : head entry, 0 when empty
//   o_full    : count == DEPTH
//   o_empty   : count == 0
//   o_count   : number of entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage carries no reset; o_data is masked to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder
// CPU-side data-bus responder. Decodes the single-cycle CPU data port:
// addresses outside the MMIO page pass straight to the synchronous RAM,
// the MMIO page holds a free-running timer with compare/match and a byte
// TX FIFO drained over a valid/ready port. Read data from both targets
// appears on cpu_out one cycle after the address.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   bus       : dbus_responder_if.slave (CPU, RAM, TX drain, timer_irq)
// Register map (cpu_addr[1:0] ignored, offsets above 0x00F read 0):
//   0x000 TIME     RW  free-running, write loads and skips that increment
//   0x004 TIMECMP  RW
//   0x008 STATUS   full, empty, match(W1C), overflow(W1C), count[6:4]
//   0x00C TXDATA   W   push byte, reads 0
// -----------------------------------------------------------------------------
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] MMIO_PAGE  = MMIO_PAGE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    dbus_responder_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Decode
    logic        w_mmio;
    logic        w_mapped;
    logic [11:0] w_off;
    logic        w_wr;
    logic        w_wr_time;
    logic        w_wr_timecmp;
    logic        w_wr_status;
    logic        w_push_req;

    // Timer / status state
    logic [31:0] r_time;
    logic [31:0] r_timecmp;
    logic        r_match;
    logic        r_ovf;
    logic        w_hit;

    // FIFO hookup
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_drop;

    // Read path
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic [31:0] r_rdata;
    sel_e        r_sel;

    // ---------------------------------------------------------------- decode
    assign w_mmio   = (bus.cpu_addr[15:12] == MMIO_PAGE);
    assign w_mapped = w_mmio && (bus.cpu_addr[11:4] == 8'h00);
    assign w_off    = {bus.cpu_addr[11:2], 2'b00};

    // MMIO writes are dropped during reset; RAM writes are not gated by rst.
    assign w_wr         = bus.cpu_wen & w_mapped & ~rst;
    assign w_wr_time    = w_wr && (w_off == OFF_TIME);
    assign w_wr_timecmp = w_wr && (w_off == OFF_TIMECMP);
    assign w_wr_status  = w_wr && (w_off == OFF_STATUS);
    assign w_push_req   = w_wr && (w_off == OFF_TXDATA);

    assign bus.ram_addr = bus.cpu_addr;
    assign bus.ram_in   = bus.cpu_in;
    assign bus.ram_wen  = bus.cpu_wen & ~w_mmio;

    // ----------------------------------------------------------------- timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_time    <= 32'h0000_0000;
            r_timecmp <= 32'hFFFF_FFFF;
        end else begin
            if (w_wr_time) begin
                r_time <= bus.cpu_in;
            end else begin
                r_time <= r_time + 32'd1;
            end
            if (w_wr_timecmp) begin
                r_timecmp <= bus.cpu_in;
            end
        end
    end

    // Match compares the registered values, so it is seen one cycle after
    // TIME reaches TIMECMP. A set in the same cycle as a W1C wins.
    assign w_hit = (r_time == r_timecmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status && bus.cpu_in[ST_MATCH]) begin
            r_match <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ FIFO
    assign w_pop  = ~w_empty & bus.tx_ready;
    assign w_drop = w_push_req & w_full & ~w_pop;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_data  (bus.cpu_in[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && bus.cpu_in[ST_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.tx_data   = w_head;
    assign bus.tx_valid  = ~w_empty;
    assign bus.timer_irq = r_match;

    // ------------------------------------------------------------- read path
    always_comb begin
        w_status                      = 32'h0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_MATCH]            = r_match;
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_CNT_HI:ST_CNT_LO] = sat_count3(32'(w_count));
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_mapped) begin
            case (w_off)
                OFF_TIME:    w_rdata = r_time;
                OFF_TIMECMP: w_rdata = r_timecmp;
                OFF_STATUS:  w_rdata = w_status;
                default:     w_rdata = 32'h0;
            endcase
        end
    end

    // MMIO data is registered so it lines up with the RAM's one-cycle latency;
    // r_sel remembers which target the previous address belonged to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
            r_sel   <= SEL_RAM;
        end else begin
            r_rdata <= w_rdata;
            r_sel   <= w_mmio ? SEL_MMIO : SEL_RAM;
        end
    end

    assign bus.cpu_out = (r_sel == SEL_MMIO) ? r_rdata : bus.ram_out;

endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam logic [15:0] A_TIME    = {4'hF, OFF_TIME};
    localparam logic [15:0] A_TIMECMP = {4'hF, OFF_TIMECMP};
    localparam logic [15:0] A_STATUS  = {4'hF, OFF_STATUS};
    localparam logic [15:0] A_TXDATA  = {4'hF, OFF_TXDATA};

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        wen;
        logic        exp_ram_wen;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_responder_if bus ();

    dbus_responder #(
        .FIFO_DEPTH (4),
        .MMIO_PAGE  (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM model, one-cycle read latency, read-before-write.
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.ram_wen) begin
            ram_mem[bus.ram_addr[9:2]] <= bus.ram_in;
        end
        bus.ram_out <= ram_mem[bus.ram_addr[9:2]];
    end

    // ------------------------------------------------------------ scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    vec_t        vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", name, bus.cpu_out);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.cpu_out, e);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] addr, input logic [31:0] data, input logic wen);
        bus.cpu_addr = addr;
        bus.cpu_in   = data;
        bus.cpu_wen  = wen;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        drive(addr, data, 1'b1);
        tick();
        bus.cpu_wen = 1'b0;
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [31:0] exp);
        drive(addr, 32'h0, 1'b0);
        exp_q.push_back(exp);
        tick();
        check_out(name);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.cpu_wen = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic accepted);
        if (accepted) tx_q.push_back(b);
        wr(A_TXDATA, {24'h0, b});
    endtask

    task automatic drain(input string name, input int n);
        logic [7:0] e;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hXX;
            check($sformatf("%s_valid%0d", name, i), {31'h0, bus.tx_valid}, 32'h1);
            check($sformatf("%s_data%0d", name, i), {24'h0, bus.tx_data}, {24'h0, e});
            tick();
        end
        check($sformatf("%s_empty", name), {31'h0, bus.tx_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- test
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
        rst          = 1'b1;
        bus.cpu_addr = 16'h0;
        bus.cpu_in   = 32'h0;
        bus.cpu_wen  = 1'b0;
        bus.tx_ready = 1'b0;

        vecs.push_back('{16'h0040, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{16'h0040, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{16'h0080, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{16'h0080, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{16'h0040, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678});
        vecs.push_back('{16'hF010, 32'h00000055, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{16'hF010, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{A_TIMECMP, 32'h00001234, 1'b1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{A_TIMECMP, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00001234});
        vecs.push_back('{16'hF006, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00001234});
        vecs.push_back('{A_STATUS, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000002});
        vecs.push_back('{A_TXDATA, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{16'hEFFC, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{16'hEFFC, 32'h0,        1'b0, 1'b0, 1'b1, 32'hCAFEF00D});
        vecs.push_back('{A_TIMECMP, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00001234});
        vecs.push_back('{16'h0080, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF});

        // Reset state
        reset_dut();
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        check("rst_irq", {31'h0, bus.timer_irq}, 32'h0);
        check("rst_cpu_out", bus.cpu_out, 32'h0);
        rd("rst_time", A_TIME, 32'h0);
        rd("rst_timecmp", A_TIMECMP, 32'hFFFFFFFF);
        rd("rst_status", A_STATUS, 32'h00000002);

        // Table-driven decode / read-latency vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].addr, vecs[i].data, vecs[i].wen);
            #1;
            check($sformatf("vec%0d_ram_wen", i), {31'h0, bus.ram_wen}, {31'h0, vecs[i].exp_ram_wen});
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
            tick();
            if (vecs[i].chk) check_out($sformatf("vec%0d_rd", i));
        end
        bus.cpu_wen = 1'b0;

        // Timer compare, sticky irq, W1C and set-wins
        reset_dut();                         // cycle 0, TIME=0
        wr(A_TIMECMP, 32'd20);               // now cycle 1
        repeat (18) tick();                  // cycle 19
        check("irq_c19", {31'h0, bus.timer_irq}, 32'h0);
        tick();                              // cycle 20, TIME==20
        check("irq_c20", {31'h0, bus.timer_irq}, 32'h0);
        tick();                              // cycle 21
        check("irq_c21", {31'h0, bus.timer_irq}, 32'h1);
        wr(A_STATUS, 32'h4);                 // cycle 22
        check("irq_clear", {31'h0, bus.timer_irq}, 32'h0);
        wr(A_TIME, 32'd18);                  // cycle 23, TIME=18
        tick();
        tick();                              // cycle 25, TIME=20
        wr(A_STATUS, 32'h4);                 // clear collides with match
        check("irq_set_wins", {31'h0, bus.timer_irq}, 32'h1);
        wr(A_STATUS, 32'h4);
        check("irq_clear2", {31'h0, bus.timer_irq}, 32'h0);
        rd("timecmp_rb", A_TIMECMP, 32'd20);

        // TIME write then reads, and wrap
        wr(A_TIME, 32'h1);
        rd("time_after_wr", A_TIME, 32'h1);
        rd("time_next", A_TIME, 32'h2);
        wr(A_TIME, 32'hFFFFFFFF);
        rd("time_max", A_TIME, 32'hFFFFFFFF);
        rd("time_wrap", A_TIME, 32'h0);

        // FIFO fill beyond depth with consumer stalled
        reset_dut();
        bus.tx_ready = 1'b0;
        drive(A_TXDATA, 32'hA1, 1'b1);
        tx_q.push_back(8'hA1);
        #1;
        check("tx_no_comb", {31'h0, bus.tx_valid}, 32'h0);
        tick();
        bus.cpu_wen = 1'b0;
        check("tx_valid_n1", {31'h0, bus.tx_valid}, 32'h1);
        push_byte(8'hA2, 1'b1);
        push_byte(8'hA3, 1'b1);
        push_byte(8'hA4, 1'b1);
        push_byte(8'hA5, 1'b0);
        rd("status_full_ovf", A_STATUS, 32'h00000049);
        check("tx_head_held", {24'h0, bus.tx_data}, 32'hA1);
        drain("drain_a", 4);

        wr(A_STATUS, 32'h8);
        rd("ovf_cleared", A_STATUS, 32'h00000002);

        // Push and pop on a full FIFO
        bus.tx_ready = 1'b0;
        push_byte(8'hC1, 1'b1);
        push_byte(8'hC2, 1'b1);
        push_byte(8'hC3, 1'b1);
        push_byte(8'hC4, 1'b1);
        bus.tx_ready = 1'b1;
        check("full_pop_head", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
        push_byte(8'hB0, 1'b1);
        bus.tx_ready = 1'b0;
        rd("status_full_pp", A_STATUS, 32'h00000041);
        drain("drain_b", 4);

        // Push and pop on an empty FIFO: push only
        bus.tx_ready = 1'b1;
        drive(A_TXDATA, 32'hD0, 1'b1);
        #1;
        check("empty_pp_valid0", {31'h0, bus.tx_valid}, 32'h0);
        tick();
        bus.cpu_wen = 1'b0;
        check("empty_pp_valid1", {31'h0, bus.tx_valid}, 32'h1);
        check("empty_pp_data", {24'h0, bus.tx_data}, 32'hD0);
        tick();
        check("empty_pp_gone", {31'h0, bus.tx_valid}, 32'h0);
        rd("empty_pp_status", A_STATUS, 32'h00000002);

        // Reset flushes queued bytes; MMIO write in reset cycle ignored
        bus.tx_ready = 1'b0;
        push_byte(8'hE1, 1'b1);
        push_byte(8'hE2, 1'b1);
        tx_q.delete();
        rst = 1'b1;
        drive(A_TXDATA, 32'hE3, 1'b1);
        #1;
        check("rst_push_ram_wen", {31'h0, bus.ram_wen}, 32'h0);
        tick();
        rst = 1'b0;
        bus.cpu_wen = 1'b0;
        check("flush_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("flush_data", {24'h0, bus.tx_data}, 32'h0);
        rd("flush_status", A_STATUS, 32'h00000002);

        // RAM write during reset still passes through
        rst = 1'b1;
        drive(16'h0100, 32'h0BADF00D, 1'b1);
        #1;
        check("rst_ram_wen", {31'h0, bus.ram_wen}, 32'h1);
        tick();
        rst = 1'b0;
        bus.cpu_wen = 1'b0;
        rd("rst_ram_rd", 16'h0100, 32'h0BADF00D);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expected reads never compared", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder on the CPU side of the data memory. It takes the single-cycle data port the CPU drives every cycle (address, write data, write enable) and decodes it. Low addresses pass through to the synchronous RAM. The top 4 KiB page is a small MMIO block: a free-running timer with compare/interrupt, and a byte TX FIFO with a valid/ready drain port. Read data returns with the same one-cycle latency as the RAM, so the CPU cannot tell the two targets apart.

## Interface
- FIFO_DEPTH, 4 — TX FIFO entries; power of two, ≥2
- MMIO_PAGE, 4'hF — value of cpu_addr[15:12] that selects MMIO
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_addr  in  16  byte address from CPU (ALU result)
- cpu_in  in  32  store data (rs2)
- cpu_wen  in  1  store strobe, one cycle per store
- cpu_out  out  32  read data, valid one cycle after cpu_addr
- ram_addr  out  16  RAM address, combinational copy of cpu_addr
- ram_in  out  32  RAM write data, copy of cpu_in
- ram_wen  out  1  cpu_wen gated to non-MMIO addresses
- ram_out  in  32  RAM read data, one cycle latency
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head this cycle
- timer_irq  out  1  sticky timer match flag

## Operation
- The bus has no read strobe. Every cycle with cpu_wen=0 is a read, so reads have no side effects.
- Decode: mmio = (cpu_addr[15:12]==MMIO_PAGE). Registered copy sel_q picks the cpu_out source next cycle.
- ram_wen = cpu_wen & ~mmio. MMIO addresses never write RAM.
- Register map, word-aligned; cpu_addr[1:0] ignored. Only offsets 0x000–0x00F are mapped. Other MMIO offsets read 0 and ignore writes.
  - 0x000 TIME, RW: increments by 1 every cycle. A write loads cpu_in and skips the increment that cycle.
  - 0x004 TIMECMP, RW.
  - 0x008 STATUS: bit0 full, bit1 empty, bit2 match, bit3 overflow, bits[6:4] count (saturates display at 7), others 0. A write of 1 to bit2 or bit3 clears that bit. Other bits are read-only.
  - 0x00C TXDATA: a write pushes cpu_in[7:0]; reads return 0.
- Match: each cycle where TIME==TIMECMP (registered values) sets match. timer_irq = match.
- Push rules:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- Pop = tx_valid & tx_ready. tx_data is stable while tx_valid=1 and tx_ready=0.

## Timing
- Read latency 1: data for the address presented in cycle N appears on cpu_out in cycle N+1.
  - MMIO reads are registered into cpu_out.
  - RAM reads select ram_out combinationally via sel_q.
- A TIME read returns the value in the request cycle, before the increment.
- A write followed by a read of the same MMIO register in the next cycle returns the new value (TIME: new value, not yet incremented).
- A push in cycle N makes tx_valid=1 from N+1 if the FIFO was empty. There is no combinational path from cpu_* to tx_*.
- Simultaneous events:
  - Match set and write-1-clear in the same cycle: set wins.
  - Push and pop on a full FIFO: both happen, count unchanged.
  - Push and pop on an empty FIFO: push only, since tx_valid was 0.
- FIFO pointers wrap modulo FIFO_DEPTH. count width is log2(FIFO_DEPTH)+1.
- TIME wraps 0xFFFFFFFF→0 without any flag.
- Reset values:
  - TIME=0, TIMECMP=0xFFFFFFFF.
  - FIFO empty, so tx_valid=0 and tx_data=0.
  - match=0, overflow=0, timer_irq=0.
  - cpu_out=0, sel_q=RAM.
- Reset mid-operation flushes the FIFO, including a byte held against tx_ready=0. A write in the reset cycle is ignored for MMIO; RAM writes still pass through.

## Structure
- Shared package dbus_pkg holds:
  - offset constants OFF_TIME/OFF_TIMECMP/OFF_STATUS/OFF_TXDATA
  - STATUS bit indices
  - default MMIO_PAGE
- Sub-module tx_fifo (params DEPTH, WIDTH=8): sync FIFO with push/pop/full/empty/count and show-ahead head output.
- Top-level holds decode, timer, status and read mux.

## Test plan
- Store 0x12345678 to 0x0040, then load 0x0040: ram_wen=1 once; cpu_out=0x12345678 one cycle after the load address.
- Store 0x1 to 0xF000, then read 0xF000 the next cycle and again two cycles later: reads return 0x1 and 0x2.
- Write TIMECMP=20 after reset: timer_irq rises the cycle after TIME==20. A write of 0x4 to STATUS in the same cycle as a match leaves irq=1; a later write clears it.
- Hold tx_ready=0 and push 0xA1..0xA5: count=4, full=1, overflow=1, tx_data=0xA1. Then set tx_ready=1: bytes A1..A4 drain in order, tx_valid falls after 4 cycles.
- With the FIFO full and tx_ready=1, push 0xB0: the push is accepted, count stays 4, and 0xB0 is last out.
- Store to 0xF010 and 0xF00C: ram_wen stays 0 for both. A read of 0xF010 returns 0. Assert rst with 2 bytes queued: next cycle tx_valid=0, STATUS=0x02.
